// File: rtl/lsu_mem_sequencer.sv
// Load/store sequencer in front of a single-port word memory: one request in flight,
// read-modify-write for sub-word stores, lane extract and extend for loads.
module lsu_mem_sequencer #(
  parameter int RD_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic [31:0] mem_addr,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [2:0] {IDLE, ERR, RD, WAIT, WR, RESP} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic        q_we, q_uns;
  logic [1:0]  q_size, q_lane;
  logic [15:0] q_wdata;
  logic        hs, bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] ld_val, mrg;

  assign hs  = req_valid & req_ready;
  assign bad = (req_size == 2'b11) ||
               (req_size == 2'b01 && req_addr[0]) ||
               (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  // Lane views of the returning memory word; only meaningful in the last WAIT cycle.
  assign lane_b = mem_rdata[{q_lane, 3'b000} +: 8];
  assign lane_h = mem_rdata[{q_lane[1], 4'b0000} +: 16];

  always_comb begin
    ld_val = mem_rdata;
    mrg    = mem_rdata;
    case (q_size)
      2'b00:   ld_val = {{24{~q_uns & lane_b[7]}}, lane_b};
      2'b01:   ld_val = {{16{~q_uns & lane_h[15]}}, lane_h};
      default: ld_val = mem_rdata;
    endcase
    if (q_size == 2'b00) mrg[{q_lane, 3'b000} +: 8] = q_wdata[7:0];
    else                 mrg[{q_lane[1], 4'b0000} +: 16] = q_wdata[15:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      q_we       <= 1'b0;
      q_uns      <= 1'b0;
      q_size     <= '0;
      q_lane     <= '0;
      q_wdata    <= '0;
      req_ready  <= 1'b1;
      resp_valid <= 1'b0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
      mem_addr   <= '0;
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
    end else begin
      // Strobes and response are single-cycle pulses unless re-armed below.
      mem_rd     <= 1'b0;
      mem_wr     <= 1'b0;
      mem_wdata  <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      unique case (state)
        IDLE: if (hs) begin
          q_we      <= req_we;
          q_uns     <= req_unsigned;
          q_size    <= req_size;
          q_lane    <= req_addr[1:0];
          q_wdata   <= req_wdata[15:0];
          req_ready <= 1'b0;
          if (bad) begin
            state      <= ERR;
            resp_valid <= 1'b1;
            resp_err   <= 1'b1;
          end else if (req_we && req_size == 2'b10) begin
            state     <= WR;
            mem_wr    <= 1'b1;
            mem_wdata <= req_wdata;
            mem_addr  <= {req_addr[31:2], 2'b00};
          end else begin
            state    <= RD;
            mem_rd   <= 1'b1;
            mem_addr <= {req_addr[31:2], 2'b00};
          end
        end
        RD: begin
          state <= WAIT;
          cnt   <= 3'(RD_LAT);
        end
        WAIT: begin
          if (cnt == 3'd1) begin
            if (q_we) begin
              state     <= WR;
              mem_wr    <= 1'b1;
              mem_wdata <= mrg;
            end else begin
              state      <= RESP;
              resp_valid <= 1'b1;
              resp_rdata <= ld_val;
            end
          end else begin
            cnt <= cnt - 3'd1;
          end
        end
        WR: begin
          state      <= RESP;
          resp_valid <= 1'b1;
        end
        ERR, RESP: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          mem_addr  <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_mem_sequencer.sv
// Bench for lsu_mem_sequencer: RD_LAT=1 instance with a word memory and a reference
// model, plus an RD_LAT=3 instance for latency and mid-operation reset.
module tb_lsu_mem_sequencer;
  localparam int LA = 1;
  localparam int LB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req_we, req_unsigned;
  logic [1:0]  req_size;
  logic [31:0] req_addr, req_wdata;
  logic        a_valid, a_ready, a_rv, a_err, a_rd, a_wr;
  logic [31:0] a_rdata, a_maddr, a_wdata, a_mrdata;
  logic        b_valid, b_ready, b_rv, b_err, b_rd, b_wr;
  logic [31:0] b_rdata, b_maddr, b_wdata, b_mrdata, b_p1, b_p2;
  logic [31:0] mem_a [64];
  logic [31:0] ref_mem [64];
  int n_cmp = 0;
  int n_bad = 0;

  typedef struct packed {
    int rv_cyc; int rv_cnt; int rd_cyc; int rd_cnt; int wr_cyc; int wr_cnt; int rdy_lo;
    logic [31:0] rdata; logic [31:0] maddr; logic [31:0] wdata; logic err; logic leak;
  } obs_t;

  lsu_mem_sequencer #(.RD_LAT(LA)) dut_a (
    .clk(clk), .rst(rst), .req_valid(a_valid), .req_ready(a_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(a_rv), .resp_rdata(a_rdata), .resp_err(a_err), .mem_addr(a_maddr),
    .mem_rd(a_rd), .mem_wr(a_wr), .mem_wdata(a_wdata), .mem_rdata(a_mrdata));

  lsu_mem_sequencer #(.RD_LAT(LB)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(b_rv), .resp_rdata(b_rdata), .resp_err(b_err), .mem_addr(b_maddr),
    .mem_rd(b_rd), .mem_wr(b_wr), .mem_wdata(b_wdata), .mem_rdata(b_mrdata));

  // Memories drive garbage except in the cycle the read data is due.
  always @(posedge clk) begin
    a_mrdata <= a_rd ? mem_a[a_maddr[7:2]] : $urandom;
    if (a_wr) mem_a[a_maddr[7:2]] <= a_wdata;
    b_p1     <= b_rd ? (32'hCAFE0000 | b_maddr) : $urandom;
    b_p2     <= b_p1;
    b_mrdata <= b_p2;
  end

  function automatic string fmt(obs_t o);
    return $sformatf("rv@%0d x%0d rd@%0d x%0d wr@%0d x%0d rdylo=%0d rdata=%h addr=%h wdata=%h err=%b leak=%b",
      o.rv_cyc, o.rv_cnt, o.rd_cyc, o.rd_cnt, o.wr_cyc, o.wr_cnt, o.rdy_lo, o.rdata, o.maddr, o.wdata, o.err, o.leak);
  endfunction

  // Expected observation for a request on the RD_LAT=1 instance; also updates the reference memory.
  function automatic obs_t ref_model(logic we, logic [1:0] sz, logic uns, logic [31:0] addr, logic [31:0] wd);
    obs_t e;
    logic bad;
    logic [31:0] w, m, v;
    int sh;
    e = '0;
    bad = (sz == 3) || (sz == 1 && addr[0]) || (sz == 2 && addr[1:0] != 0);
    e.rv_cnt = 1;
    if (bad) begin
      e.rv_cyc = 1; e.err = 1; e.rdy_lo = 1;
      return e;
    end
    w = ref_mem[addr[7:2]];
    sh = 8 * addr[1:0];
    m = (sz == 0) ? 32'hFF : (sz == 1) ? 32'hFFFF : 32'hFFFFFFFF;
    e.maddr = {addr[31:2], 2'b00};
    if (we) begin
      e.wr_cnt = 1;
      if (sz == 2) begin
        e.wr_cyc = 1; e.rv_cyc = 2; e.wdata = wd;
      end else begin
        e.rd_cnt = 1; e.rd_cyc = 1; e.wr_cyc = 2 + LA; e.rv_cyc = 3 + LA;
        e.wdata = (w & ~(m << sh)) | ((wd & m) << sh);
      end
      ref_mem[addr[7:2]] = e.wdata;
    end else begin
      e.rd_cnt = 1; e.rd_cyc = 1; e.rv_cyc = 2 + LA;
      v = (w >> sh) & m;
      if (!uns && sz == 0 && v[7])  v = v | 32'hFFFFFF00;
      if (!uns && sz == 1 && v[15]) v = v | 32'hFFFF0000;
      e.rdata = v;
    end
    e.rdy_lo = e.rv_cyc;
    return e;
  endfunction

  // Issue one request on instance A and record 10 cycles of outputs, scrambling inputs once captured.
  task automatic issue(input logic we, input logic [1:0] sz, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wd, output obs_t o);
    int w;
    w = 0;
    o = '0;
    @(negedge clk);
    while (!a_ready && w < 10) begin @(negedge clk); w++; end
    if (!a_ready) begin o.rv_cyc = -1; return; end
    a_valid = 1'b1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = addr; req_wdata = wd;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      if (k == 1) begin
        a_valid = 1'b0; req_we = 1'($urandom); req_size = 2'($urandom); req_unsigned = 1'($urandom);
        req_addr = $urandom; req_wdata = $urandom;
      end
      if (a_rv) begin o.rv_cnt++; o.rv_cyc = k; o.rdata = a_rdata; o.err = a_err; end
      if (a_rd) begin o.rd_cnt++; o.rd_cyc = k; o.maddr = a_maddr; end
      if (a_wr) begin o.wr_cnt++; o.wr_cyc = k; o.maddr = a_maddr; o.wdata = a_wdata; end
      else if (a_wdata !== 32'h0) o.leak = 1'b1;
      if (!a_ready) o.rdy_lo++;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    #2 rst = 1'b0;
    #10;
    n_cmp++; if ({a_ready, b_ready} !== 2'b11) begin n_bad++; $display("FAIL reset_ready got %b want 11", {a_ready, b_ready}); end
    n_cmp++; if ({a_rv, a_err, a_rd, a_wr, a_rdata, a_maddr, a_wdata} !== 100'h0) begin n_bad++;
      $display("FAIL reset_outputs got rv=%b err=%b rd=%b wr=%b rdata=%h addr=%h wdata=%h want all 0",
        a_rv, a_err, a_rd, a_wr, a_rdata, a_maddr, a_wdata); end
    @(negedge clk) rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++; if (a_ready !== 1'b1) begin n_bad++; $display("FAIL post_reset_ready got %b want 1", a_ready); end
  endtask

  task automatic test_sw;
    obs_t o, e;
    e = ref_model(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF);
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, o);
    n_cmp++; if (o.wr_cyc !== 1 || o.wr_cnt !== 1 || o.rd_cnt !== 0) begin n_bad++; $display("FAIL sw_strobe got %s want wr@1 x1 rd x0", fmt(o)); end
    n_cmp++; if (o.maddr !== 32'h10 || o.wdata !== 32'hDEADBEEF) begin n_bad++; $display("FAIL sw_data got addr=%h wdata=%h want 10 deadbeef", o.maddr, o.wdata); end
    n_cmp++; if (o.rv_cyc !== 2 || o.rv_cnt !== 1 || o.err !== 1'b0) begin n_bad++; $display("FAIL sw_resp got %s want rv@2 x1 err=0", fmt(o)); end
  endtask

  task automatic test_fill;
    obs_t o, e;
    logic [31:0] r, ad, d;
    for (int i = 0; i < 64; i++) begin
      r = $urandom; d = $urandom;
      ad = {r[31:8], 6'(i), 2'b00};
      e = ref_model(1'b1, 2'b10, 1'b0, ad, d);
      issue(1'b1, 2'b10, 1'b0, ad, d, o);
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL fill[%0d] got %s want %s", i, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_load_ext;
    obs_t o, e;
    e = ref_model(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F17F01);
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'h80F17F01, o);
    e = ref_model(1'b0, 2'b00, 1'b0, 32'h21, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h21, 32'h0, o);
    n_cmp++; if (o.rdata !== 32'h0000007F || o.rv_cyc !== 3) begin n_bad++; $display("FAIL lb_21 got %s want rdata=0000007f rv@3", fmt(o)); end
    n_cmp++; if (o.rd_cyc !== 1 || o.rd_cnt !== 1 || o.maddr !== 32'h20 || o.wr_cnt !== 0) begin n_bad++; $display("FAIL lb_21_mem got %s want rd@1 x1 addr=20", fmt(o)); end
    e = ref_model(1'b0, 2'b00, 1'b0, 32'h23, 32'h0);
    issue(1'b0, 2'b00, 1'b0, 32'h23, 32'h0, o);
    n_cmp++; if (o.rdata !== 32'hFFFFFF80) begin n_bad++; $display("FAIL lb_23 got %h want ffffff80", o.rdata); end
    e = ref_model(1'b0, 2'b01, 1'b1, 32'h22, 32'h0);
    issue(1'b0, 2'b01, 1'b1, 32'h22, 32'h0, o);
    n_cmp++; if (o.rdata !== 32'h000080F1) begin n_bad++; $display("FAIL lhu_22 got %h want 000080f1", o.rdata); end
    e = ref_model(1'b0, 2'b01, 1'b0, 32'h22, 32'h0);
    issue(1'b0, 2'b01, 1'b0, 32'h22, 32'h0, o);
    n_cmp++; if (o.rdata !== 32'hFFFF80F1) begin n_bad++; $display("FAIL lh_22 got %h want ffff80f1", o.rdata); end
    e = ref_model(1'b0, 2'b10, 1'b1, 32'h20, 32'h0);
    issue(1'b0, 2'b10, 1'b1, 32'h20, 32'h0, o);
    n_cmp++; if (o.rdata !== 32'h80F17F01) begin n_bad++; $display("FAIL lw_20 got %h want 80f17f01", o.rdata); end
  endtask

  task automatic test_sb;
    obs_t o, e;
    e = ref_model(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344);
    issue(1'b1, 2'b10, 1'b0, 32'h40, 32'h11223344, o);
    e = ref_model(1'b1, 2'b00, 1'b0, 32'h42, 32'h555555AA);
    issue(1'b1, 2'b00, 1'b0, 32'h42, 32'h555555AA, o);
    n_cmp++; if (o.rd_cnt !== 1 || o.wr_cnt !== 1 || o.wr_cyc !== 3) begin n_bad++; $display("FAIL sb_strobes got %s want rd x1 wr@3 x1", fmt(o)); end
    n_cmp++; if (o.wdata !== 32'h11AA3344 || o.maddr !== 32'h40) begin n_bad++; $display("FAIL sb_merge got wdata=%h addr=%h want 11aa3344 40", o.wdata, o.maddr); end
    n_cmp++; if (o.rv_cyc !== 4 || o.rdata !== 32'h0) begin n_bad++; $display("FAIL sb_resp got %s want rv@4 rdata=0", fmt(o)); end
    e = ref_model(1'b1, 2'b01, 1'b0, 32'h42, 32'h9876BEEF);
    issue(1'b1, 2'b01, 1'b0, 32'h42, 32'h9876BEEF, o);
    n_cmp++; if (o.wdata !== 32'hBEEF3344) begin n_bad++; $display("FAIL sh_merge got %h want beef3344", o.wdata); end
  endtask

  task automatic test_err;
    obs_t o;
    logic [31:0] ad [4];
    logic [1:0]  sz [4];
    logic        we [4];
    ad = '{32'h6, 32'h5, 32'h0, 32'h3};
    sz = '{2'b10, 2'b01, 2'b11, 2'b01};
    we = '{1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i < 4; i++) begin
      issue(we[i], sz[i], 1'b0, ad[i], 32'hFFFFFFFF, o);
      n_cmp++; if (o.rv_cyc !== 1 || o.rv_cnt !== 1 || o.err !== 1'b1 || o.rdata !== 32'h0) begin n_bad++; $display("FAIL err_resp[%0d] got %s want rv@1 x1 err=1 rdata=0", i, fmt(o)); end
      n_cmp++; if (o.rd_cnt !== 0 || o.wr_cnt !== 0) begin n_bad++; $display("FAIL err_mem[%0d] got rd x%0d wr x%0d want 0 0", i, o.rd_cnt, o.wr_cnt); end
    end
  endtask

  task automatic test_random;
    obs_t o, e;
    logic we, uns;
    logic [1:0] sz;
    logic [31:0] ad, d;
    for (int i = 0; i < 200; i++) begin
      we = 1'($urandom); uns = 1'($urandom); sz = 2'($urandom); ad = $urandom; d = $urandom;
      if ($urandom_range(0, 2) != 0) ad[1:0] = ad[1:0] & ((sz == 2) ? 2'b00 : (sz == 1) ? 2'b10 : 2'b11);
      e = ref_model(we, sz, uns, ad, d);
      issue(we, sz, uns, ad, d, o);
      n_cmp++; if (o !== e) begin n_bad++; $display("FAIL rand[%0d] we=%b sz=%0d uns=%b addr=%h wd=%h got %s want %s", i, we, sz, uns, ad, d, fmt(o), fmt(e)); end
    end
  endtask

  task automatic test_back_to_back;
    int hs_cyc [$];
    int wrs;
    logic [31:0] r, d;
    wrs = 0;
    @(negedge clk);
    a_valid = 1'b1; req_we = 1'b1; req_size = 2'b10; req_unsigned = 1'b0;
    for (int c = 0; c < 30; c++) begin
      r = $urandom; d = $urandom;
      req_addr = {r[31:2], 2'b00}; req_wdata = d;
      if (a_wr) wrs++;
      if (a_ready) begin hs_cyc.push_back(c); void'(ref_model(1'b1, 2'b10, 1'b0, req_addr, d)); end
      @(negedge clk);
    end
    a_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin if (a_wr) wrs++; @(negedge clk); end
    n_cmp++; if (hs_cyc.size() !== 10) begin n_bad++; $display("FAIL b2b_count got %0d want 10", hs_cyc.size()); end
    for (int i = 1; i < hs_cyc.size(); i++) begin
      n_cmp++; if (hs_cyc[i] - hs_cyc[i-1] !== 3) begin n_bad++; $display("FAIL b2b_gap[%0d] got %0d want 3", i, hs_cyc[i] - hs_cyc[i-1]); end
    end
    n_cmp++; if (wrs !== hs_cyc.size()) begin n_bad++; $display("FAIL b2b_writes got %0d want %0d", wrs, hs_cyc.size()); end
  endtask

  task automatic test_rdlat3;
    logic [8:0] lo;
    int rv_cyc, rv_cnt, rd_cyc;
    logic [31:0] rdata;
    lo = '0; rv_cyc = 0; rv_cnt = 0; rd_cyc = 0; rdata = '0;
    @(negedge clk);
    b_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h100; req_wdata = 32'h0;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      if (k == 1) begin b_valid = 1'b0; req_addr = $urandom; req_we = 1'($urandom); req_size = 2'($urandom); end
      lo[k] = ~b_ready;
      if (b_rv) begin rv_cnt++; rv_cyc = k; rdata = b_rdata; end
      if (b_rd) rd_cyc = k;
    end
    n_cmp++; if (lo !== 9'b000111110) begin n_bad++; $display("FAIL lat3_ready_low got %b want 000111110", lo); end
    n_cmp++; if (rv_cyc !== 5 || rv_cnt !== 1 || rd_cyc !== 1) begin n_bad++; $display("FAIL lat3_timing got rv@%0d x%0d rd@%0d want rv@5 x1 rd@1", rv_cyc, rv_cnt, rd_cyc); end
    n_cmp++; if (rdata !== 32'hCAFE0100) begin n_bad++; $display("FAIL lat3_rdata got %h want cafe0100", rdata); end
  endtask

  task automatic test_reset_mid;
    int rvs;
    rvs = 0;
    @(negedge clk);
    b_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_addr = 32'h104;
    @(negedge clk);
    b_valid = 1'b0;
    n_cmp++; if (b_rd !== 1'b1) begin n_bad++; $display("FAIL rstmid_rd got %b want 1", b_rd); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if ({b_ready, b_rd, b_rv, b_wr} !== 4'b1000) begin n_bad++; $display("FAIL rstmid_abort got ready,rd,rv,wr=%b want 1000", {b_ready, b_rd, b_rv, b_wr}); end
    repeat (2) begin @(negedge clk); if (b_rv) rvs++; end
    rst = 1'b1;
    repeat (8) begin @(negedge clk); if (b_rv) rvs++; end
    n_cmp++; if (rvs !== 0 || b_ready !== 1'b1) begin n_bad++; $display("FAIL rstmid_noresp got resp_count=%0d ready=%b want 0 1", rvs, b_ready); end
  endtask

  initial begin
    a_valid = 1'b0; b_valid = 1'b0; req_we = 1'b0; req_size = 2'b00; req_unsigned = 1'b0;
    req_addr = '0; req_wdata = '0;
    test_reset();
    test_sw();
    test_fill();
    test_load_ext();
    test_sb();
    test_err();
    test_random();
    test_back_to_back();
    test_rdlat3();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout after %0d comparisons", n_cmp);
    $fatal(1);
  end
endmodule
